// File: rtl/fir_sched_pkg.sv
// fir_sched_pkg: shared state enum, tap tag struct and width helper for fir_band_scheduler
package fir_sched_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, RUN, DRAIN} state_t;
  localparam int MAX_CHW = 8;
  typedef struct packed {
    logic first;
    logic last;
    logic [MAX_CHW-1:0] ch;
  } tag_t;
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fir_band_scheduler_if.sv
// fir_band_scheduler_if: sample input, host coefficient-write port and band result stream
interface fir_band_scheduler_if #(parameter int DW = 16, parameter int CAW = 9, parameter int CHW = 2, parameter int ACC_W = 40);
  logic sample_valid;
  logic signed [DW-1:0] sample_data;
  logic host_req;
  logic [CAW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic host_ack;
  logic res_valid;
  logic [CHW-1:0] res_ch;
  logic signed [ACC_W-1:0] res_data;
  modport master(output sample_valid, sample_data, host_req, host_addr, host_wdata,
                 input host_ack, res_valid, res_ch, res_data);
  modport slave(input sample_valid, sample_data, host_req, host_addr, host_wdata,
                output host_ack, res_valid, res_ch, res_data);
endinterface

// File: rtl/fir_mac_pipe.sv
// fir_mac_pipe: product and accumulate stages with tag pipeline; optional saturation via FIR_SCHED_SATURATE_EN
module fir_mac_pipe
  import fir_sched_pkg::*;
#(parameter int DW = 16, parameter int ACC_W = 40, parameter int CHW = 2)
(
  input  logic clk,
  input  logic nreset,
  input  logic in_v,
  input  tag_t in_tag,
  input  logic signed [DW-1:0] coef,
  input  logic signed [DW-1:0] smp,
  output logic res_valid,
  output logic [CHW-1:0] res_ch,
  output logic signed [ACC_W-1:0] res_data
`ifdef FIR_SCHED_SATURATE_EN
  , output logic acc_sat
`endif
);
  logic v1, v2, unused_ch;
  tag_t t1, t2;
  logic signed [2*DW-1:0] prod;
  logic signed [ACC_W-1:0] acc, acc_nx, pe;
  assign pe = ACC_W'(prod);
  assign unused_ch = ^t2.ch;
`ifdef FIR_SCHED_SATURATE_EN
  logic signed [ACC_W:0] sum;
  logic ovf;
  assign sum = (ACC_W+1)'(acc) + (ACC_W+1)'(pe);
  assign ovf = sum[ACC_W] != sum[ACC_W-1];
  assign acc_nx = t2.first ? pe : ovf ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
  // sticky saturation flag, cleared when a band restarts at its first tap
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) acc_sat <= 1'b0;
    else if (v2) acc_sat <= t2.first ? 1'b0 : acc_sat | ovf;
`else
  assign acc_nx = t2.first ? pe : acc + pe;
`endif
  // RAM data arrives one cycle after issue: register product, then accumulate and emit on last tap
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      t1 <= '0;
      t2 <= '0;
      prod <= '0;
      acc <= '0;
      res_valid <= 1'b0;
      res_ch <= '0;
      res_data <= '0;
    end else begin
      v1 <= in_v;
      t1 <= in_tag;
      v2 <= v1;
      t2 <= t1;
      if (v1) prod <= coef * smp;
      if (v2) acc <= acc_nx;
      res_valid <= v2 && t2.last;
      if (v2 && t2.last) begin
        res_ch <= t2.ch[CHW-1:0];
        res_data <= acc_nx;
      end
    end
endmodule

// File: rtl/fir_band_scheduler.sv
// fir_band_scheduler: shares one MAC across NCH FIR bands; optional FIR_SCHED_SATURATE_EN adds acc_sat
module fir_band_scheduler
  import fir_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int TAPS = 128,
  parameter int DW = 16,
  parameter int ACC_W = 40,
  localparam int AW = idx_w(TAPS),
  localparam int CHW = idx_w(NCH),
  localparam int CAW = CHW + AW
)
(
  input  logic clk,
  input  logic nreset,
  fir_band_scheduler_if.slave bus,
  input  logic ovr_clr,
  output logic busy,
  output logic overrun,
  output logic buf_we,
  output logic [AW-1:0] buf_wr_addr,
  output logic signed [DW-1:0] buf_wdata,
  output logic [AW-1:0] buf_rd_addr,
  input  logic signed [DW-1:0] buf_rd_data,
  output logic coef_we,
  output logic [CAW-1:0] coef_addr,
  output logic [DW-1:0] coef_wdata,
  input  logic signed [DW-1:0] coef_rd_data
`ifdef FIR_SCHED_SATURATE_EN
  , output logic acc_sat
`endif
);
  state_t st;
  logic [AW-1:0] wr_ptr, k;
  logic [CHW-1:0] ch;
  logic [1:0] dcnt;
  logic signed [DW-1:0] smp;
  logic grant, run;
  tag_t tag;
  assign run = st == RUN;
  assign busy = st != IDLE;
  assign grant = st == IDLE && bus.host_req && !bus.sample_valid;
  assign bus.host_ack = grant;
  assign coef_we = grant;
  assign coef_wdata = grant ? bus.host_wdata : '0;
  assign coef_addr = run ? {ch, k} : grant ? bus.host_addr : '0;
  assign buf_we = st == WRITE;
  assign buf_wr_addr = wr_ptr;
  assign buf_wdata = smp;
  assign buf_rd_addr = run ? wr_ptr - AW'(1) - k : '0;
  assign tag = '{first: k == '0, last: k == AW'(TAPS-1), ch: MAX_CHW'(ch)};
  // sample sequencing: accept, write to ring buffer, walk all band taps, drain the MAC pipe
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      st <= IDLE;
      wr_ptr <= '0;
      k <= '0;
      ch <= '0;
      dcnt <= '0;
      smp <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= bus.sample_valid && busy ? 1'b1 : ovr_clr ? 1'b0 : overrun;
      case (st)
        IDLE: if (bus.sample_valid) begin
          st <= WRITE;
          smp <= bus.sample_data;
        end
        WRITE: begin
          st <= RUN;
          wr_ptr <= wr_ptr + AW'(1);
          k <= '0;
          ch <= '0;
        end
        RUN: begin
          k <= k + AW'(1);
          if (k == AW'(TAPS-1)) begin
            ch <= ch + CHW'(1);
            if (ch == CHW'(NCH-1)) begin
              st <= DRAIN;
              dcnt <= '0;
            end
          end
        end
        default: begin
          dcnt <= dcnt + 2'd1;
          if (dcnt == 2'd2) st <= IDLE;
        end
      endcase
    end
  fir_mac_pipe #(.DW(DW), .ACC_W(ACC_W), .CHW(CHW)) u_mac (
    .clk(clk),
    .nreset(nreset),
    .in_v(run),
    .in_tag(tag),
    .coef(coef_rd_data),
    .smp(buf_rd_data),
    .res_valid(bus.res_valid),
    .res_ch(bus.res_ch),
    .res_data(bus.res_data)
`ifdef FIR_SCHED_SATURATE_EN
    , .acc_sat(acc_sat)
`endif
  );
endmodule
